// File: rtl/render_scheduler.sv
// Per-line renderer sequencer: launches layer0/layer1/sprite renderers, arbitrates their fetches
// onto one VRAM read port and recovers from line overruns. RENDER_SCHED_STATS_EN adds statistics.
module render_scheduler #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned SPR_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_render_start_i,
  input  logic [8:0]        line_idx_i,
  input  logic              layer0_enabled_i,
  input  logic              layer1_enabled_i,
  input  logic              sprites_enabled_i,
  output logic [8:0]        render_line_o,
  output logic              l0_start_o,
  output logic              l1_start_o,
  output logic              spr_start_o,
  output logic              render_abort_o,
  input  logic              l0_done_i,
  input  logic              l1_done_i,
  input  logic              spr_done_i,
  input  logic              l0_req_i,
  input  logic              l1_req_i,
  input  logic              spr_req_i,
  input  logic [ADDR_W-1:0] l0_addr_i,
  input  logic [ADDR_W-1:0] l1_addr_i,
  input  logic [ADDR_W-1:0] spr_addr_i,
  output logic              l0_ack_o,
  output logic              l1_ack_o,
  output logic              spr_ack_o,
  output logic              vram_req_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [1:0]        vram_grant_o,
  input  logic              vram_ack_i,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              overrun_clr_i
`ifdef RENDER_SCHED_STATS_EN
  ,
  output logic [7:0]        overrun_count_o,
  output logic [15:0]       max_render_cycles_o
`endif
);

  typedef enum logic [1:0] {StIdle, StStart, StRender, StDrain} state_e;

  localparam logic [1:0] GntL0   = 2'd0;
  localparam logic [1:0] GntL1   = 2'd1;
  localparam logic [1:0] GntSpr  = 2'd2;
  localparam logic [1:0] GntNone = 2'd3;

  state_e      state_q, state_d;
  logic [8:0]  line_q, line_d;
  logic [2:0]  en_q, en_d;      // {spr, l1, l0}
  logic [2:0]  pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        ovr_evt;

  logic [1:0]        gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win;

  logic [2:0] req_vec, done_vec, en_in;
  logic       xfer_busy, xfer_done, outstanding;

  assign req_vec     = {spr_req_i, l1_req_i, l0_req_i};
  assign done_vec    = {spr_done_i, l1_done_i, l0_done_i};
  assign en_in       = {sprites_enabled_i, layer1_enabled_i, layer0_enabled_i};
  assign xfer_busy   = (gnt_q != GntNone);
  assign xfer_done   = xfer_busy & vram_ack_i;
  assign outstanding = xfer_busy & ~vram_ack_i;

  // Sequencer
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    en_d    = en_q;
    pend_d  = pend_q;
    ovr_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_render_start_i) begin
          line_d  = line_idx_i;
          en_d    = en_in;
          state_d = StStart;
        end
      end
      StStart, StRender: begin
        pend_d = (state_q == StStart) ? en_q : (pend_q & ~done_vec);
        if (line_render_start_i) begin
          ovr_evt = 1'b1;
          line_d  = line_idx_i;
          en_d    = en_in;
          // A fetch in flight must complete before the renderers restart.
          state_d = outstanding ? StDrain : StStart;
        end else if (state_q == StStart) begin
          state_d = StRender;
        end else if (pend_d == 3'b000) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (line_render_start_i) begin
          line_d = line_idx_i;
          en_d   = en_in;
        end
        if (xfer_done) state_d = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (overrun_clr_i) ovr_d = 1'b0;
    if (ovr_evt)       ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      line_q  <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign render_line_o                        = line_q;
  assign {spr_start_o, l1_start_o, l0_start_o} = (state_q == StStart) ? en_q : 3'b000;
  assign render_abort_o                       = ovr_evt;
  assign busy_o                               = (state_q != StIdle);
  assign overrun_o                            = ovr_q;

  // Arbiter
  function automatic logic [1:0] pick3(input logic [2:0] r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] c);
    if (r[a]) return a;
    if (r[b]) return b;
    if (r[c]) return c;
    return GntNone;
  endfunction

  always_comb begin
    win = GntNone;
    if (SPR_PRIO != 0) begin
      if (spr_req_i)           win = GntSpr;
      else if (ptr_q == GntL1) win = pick3(req_vec & 3'b011, GntL1, GntL0, GntL0);
      else                     win = pick3(req_vec & 3'b011, GntL0, GntL1, GntL1);
    end else begin
      unique case (ptr_q)
        GntL1:   win = pick3(req_vec, GntL1, GntSpr, GntL0);
        GntSpr:  win = pick3(req_vec, GntSpr, GntL0, GntL1);
        default: win = pick3(req_vec, GntL0, GntL1, GntSpr);
      endcase
    end
  end

  always_comb begin
    gnt_d  = gnt_q;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    if (!xfer_busy) begin
      if (win != GntNone) begin
        gnt_d = win;
        unique case (win)
          GntL0:   addr_d = l0_addr_i;
          GntL1:   addr_d = l1_addr_i;
          default: addr_d = spr_addr_i;
        endcase
        if (SPR_PRIO != 0) begin
          // Sprites do not disturb the layer round-robin.
          if (win != GntSpr) ptr_d = (win == GntL0) ? GntL1 : GntL0;
        end else begin
          ptr_d = (win == GntSpr) ? GntL0 : win + 2'd1;
        end
      end
    end else if (vram_ack_i) begin
      gnt_d = GntNone;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q  <= GntNone;
      addr_q <= '0;
      ptr_q  <= GntL0;
    end else begin
      gnt_q  <= gnt_d;
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
    end
  end

  assign vram_req_o   = xfer_busy;
  assign vram_addr_o  = addr_q;
  assign vram_grant_o = gnt_q;
  assign l0_ack_o     = xfer_done & (gnt_q == GntL0);
  assign l1_ack_o     = xfer_done & (gnt_q == GntL1);
  assign spr_ack_o    = xfer_done & (gnt_q == GntSpr);

`ifdef RENDER_SCHED_STATS_EN
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;
  logic [15:0] cyc_q, cyc_d, max_q, max_d, len;

  // len counts busy cycles of the current line including the present one.
  assign len = cyc_q + {15'd0, (cyc_q != 16'hffff)};

  always_comb begin
    ovr_cnt_d = overrun_clr_i ? 8'd0 : ovr_cnt_q;
    if (ovr_evt && ovr_cnt_d != 8'hff) ovr_cnt_d = ovr_cnt_d + 8'd1;

    cyc_d = cyc_q;
    if (state_d == StStart)      cyc_d = '0;
    else if (state_q != StIdle)  cyc_d = len;

    max_d = max_q;
    if (overrun_clr_i) begin
      max_d = '0;
    end else if (state_q != StIdle && state_d == StIdle && len > max_q) begin
      max_d = len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
      cyc_q     <= '0;
      max_q     <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      cyc_q     <= cyc_d;
      max_q     <= max_d;
    end
  end

  assign overrun_count_o     = ovr_cnt_q;
  assign max_render_cycles_o = max_q;
`endif

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench for render_scheduler: instance a uses round-robin, instance b sprite priority.
module tb_render_scheduler;
  localparam int unsigned AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start, clr;
  logic [8:0]    idx;
  logic [2:0]    en, done;
  logic [2:0]    req_a, req_b;
  logic          vack_a, vack_b;
  logic [AW-1:0] a0, a1, a2;

  wire [8:0]    line_a, line_b;
  wire [2:0]    st_a, st_b, ack_a, ack_b;
  wire          abort_a, abort_b, vreq_a, vreq_b, busy_a, busy_b, ovr_a, ovr_b;
  wire [AW-1:0] vaddr_a, vaddr_b;
  wire [1:0]    gnt_a, gnt_b;
`ifdef RENDER_SCHED_STATS_EN
  wire [7:0]  cnt_a, cnt_b;
  wire [15:0] max_a, max_b;
`endif

  render_scheduler #(.ADDR_W(AW), .SPR_PRIO(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .line_render_start_i(start), .line_idx_i(idx),
    .layer0_enabled_i(en[0]), .layer1_enabled_i(en[1]), .sprites_enabled_i(en[2]),
    .render_line_o(line_a),
    .l0_start_o(st_a[0]), .l1_start_o(st_a[1]), .spr_start_o(st_a[2]),
    .render_abort_o(abort_a),
    .l0_done_i(done[0]), .l1_done_i(done[1]), .spr_done_i(done[2]),
    .l0_req_i(req_a[0]), .l1_req_i(req_a[1]), .spr_req_i(req_a[2]),
    .l0_addr_i(a0), .l1_addr_i(a1), .spr_addr_i(a2),
    .l0_ack_o(ack_a[0]), .l1_ack_o(ack_a[1]), .spr_ack_o(ack_a[2]),
    .vram_req_o(vreq_a), .vram_addr_o(vaddr_a), .vram_grant_o(gnt_a), .vram_ack_i(vack_a),
    .busy_o(busy_a), .overrun_o(ovr_a), .overrun_clr_i(clr)
`ifdef RENDER_SCHED_STATS_EN
    , .overrun_count_o(cnt_a), .max_render_cycles_o(max_a)
`endif
  );

  render_scheduler #(.ADDR_W(AW), .SPR_PRIO(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .line_render_start_i(start), .line_idx_i(idx),
    .layer0_enabled_i(en[0]), .layer1_enabled_i(en[1]), .sprites_enabled_i(en[2]),
    .render_line_o(line_b),
    .l0_start_o(st_b[0]), .l1_start_o(st_b[1]), .spr_start_o(st_b[2]),
    .render_abort_o(abort_b),
    .l0_done_i(done[0]), .l1_done_i(done[1]), .spr_done_i(done[2]),
    .l0_req_i(req_b[0]), .l1_req_i(req_b[1]), .spr_req_i(req_b[2]),
    .l0_addr_i(a0), .l1_addr_i(a1), .spr_addr_i(a2),
    .l0_ack_o(ack_b[0]), .l1_ack_o(ack_b[1]), .spr_ack_o(ack_b[2]),
    .vram_req_o(vreq_b), .vram_addr_o(vaddr_b), .vram_grant_o(gnt_b), .vram_ack_i(vack_b),
    .busy_o(busy_b), .overrun_o(ovr_b), .overrun_clr_i(clr)
`ifdef RENDER_SCHED_STATS_EN
    , .overrun_count_o(cnt_b), .max_render_cycles_o(max_b)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int age_a = 0, age_b = 0;
  int ack_delay = 2;
  bit auto_req = 0, auto_ack = 0;
  int g_a[$], g_b[$], t_a[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the requester/VRAM models update inputs 1 time unit after the edge.
  task automatic tick();
    logic [2:0] pa, pb;
    @(negedge clk);
    pa = ack_a;
    pb = ack_b;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_req) begin
      req_a = ~pa;
      req_b = ~pb;
    end
    age_a = vreq_a ? age_a + 1 : 0;
    age_b = vreq_b ? age_b + 1 : 0;
    if (auto_ack) begin
      vack_a = (age_a == ack_delay + 1);
      vack_b = (age_b == ack_delay + 1);
    end
    if (vreq_a && age_a == 1) begin
      g_a.push_back(int'(gnt_a));
      t_a.push_back(cyc);
    end
    if (vreq_b && age_b == 1) g_b.push_back(int'(gnt_b));
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_a[6];
    int exp_b[6];
    exp_a = '{0, 1, 2, 0, 1, 2};
    exp_b = '{2, 0, 2, 1, 2, 0};
    start = 0; clr = 0; idx = '0; en = '0; done = '0;
    req_a = '0; req_b = '0; vack_a = 0; vack_b = 0;
    a0 = 17'h00100; a1 = 17'h00200; a2 = 17'h1f000;
    rst = 1;
    tick();
    tick();
    rst = 0;
    check_eq("rst busy", busy_a, 0);
    check_eq("rst grant", gnt_a, 3);
    check_eq("rst vreq", vreq_a, 0);
    check_eq("rst overrun", ovr_a, 0);
    check_eq("rst line", line_a, 0);
    check_eq("rst starts", st_a, 0);

    // All enabled, line 37, done pulses at +10/+20/+30
    base = cyc;
    idx = 9'd37; en = 3'b111; start = 1;
    tick();
    start = 0;
    check_eq("l37 starts", st_a, 3'b111);
    check_eq("l37 line", line_a, 37);
    check_eq("l37 busy", busy_a, 1);
    tick();
    check_eq("l37 start one-shot", st_a, 0);
    run_to(base + 10); done = 3'b001; tick(); done = 0;
    run_to(base + 20); done = 3'b010; tick(); done = 0;
    run_to(base + 30); done = 3'b100;
    check_eq("l37 busy at last done", busy_a, 1);
    tick(); done = 0;
    check_eq("l37 busy after last done", busy_a, 0);

    // Only layer1 enabled; foreign done pulses ignored
    idx = 9'd5; en = 3'b010; start = 1;
    tick();
    start = 0;
    check_eq("l1only starts", st_a, 3'b010);
    tick();
    done = 3'b101;
    tick();
    done = 0;
    check_eq("l1only ignore foreign done", busy_a, 1);
    done = 3'b010;
    tick();
    done = 0;
    check_eq("l1only done to idle", busy_a, 0);

    // Nothing enabled: START -> RENDER -> IDLE
    en = 3'b000; start = 1;
    tick();
    start = 0;
    check_eq("noen starts", st_a, 0);
    check_eq("noen busy start", busy_a, 1);
    tick();
    check_eq("noen busy render", busy_a, 1);
    tick();
    check_eq("noen idle", busy_a, 0);

    // Arbitration with continuous requesters and ack two cycles after grant
    g_a.delete(); g_b.delete(); t_a.delete();
    ack_delay = 2; auto_ack = 1; auto_req = 1;
    req_a = 3'b111; req_b = 3'b111;
    repeat (30) tick();
    auto_req = 0; req_a = '0; req_b = '0;
    for (int i = 0; i < 20 && (vreq_a || vreq_b); i++) tick();
    check_eq("arb drained", {vreq_a, vreq_b}, 2'b00);
    auto_ack = 0; vack_a = 0; vack_b = 0;
    tick();
    check_eq("rr grant count", g_a.size() >= 6, 1);
    check_eq("prio grant count", g_b.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rr grant %0d", i), g_a[i], exp_a[i]);
      check_eq($sformatf("prio grant %0d", i), g_b[i], exp_b[i]);
    end
    for (int i = 0; i < 5; i++) check_eq($sformatf("rr spacing %0d", i), t_a[i+1] - t_a[i], 4);

    // Overrun during RENDER with a fetch outstanding
    idx = 9'd100; en = 3'b111; start = 1;
    tick();
    start = 0;
    tick();
    req_a = 3'b001;
    tick();
    check_eq("ovr grant l0", gnt_a, 0);
    check_eq("ovr vaddr", vaddr_a, a0);
    idx = 9'd200; en = 3'b101; start = 1;
    #1;
    check_eq("ovr abort pulse", abort_a, 1);
    tick();
    start = 0;
    check_eq("ovr flag", ovr_a, 1);
    check_eq("ovr abort one-shot", abort_a, 0);
    check_eq("drain no starts", st_a, 0);
    tick();
    idx = 9'd201; en = 3'b011; start = 1;
    #1;
    check_eq("drain relatch no abort", abort_a, 0);
    tick();
    start = 0;
    tick();
    check_eq("drain vreq held", vreq_a, 1);
    check_eq("drain vaddr held", vaddr_a, a0);
    check_eq("drain grant held", gnt_a, 0);
    vack_a = 1;
    #1;
    check_eq("drain ack forwarded", ack_a, 3'b001);
    tick();
    vack_a = 0; req_a = '0;
    check_eq("restart starts", st_a, 3'b011);
    check_eq("restart line", line_a, 201);
    check_eq("restart grant idle", gnt_a, 3);
    tick();
    done = 3'b011;
    tick();
    done = 0;
    check_eq("restart line done", busy_a, 0);

    // overrun_clr alone, then together with a second overrun
    clr = 1;
    tick();
    clr = 0;
    check_eq("clr clears overrun", ovr_a, 0);
`ifdef RENDER_SCHED_STATS_EN
    check_eq("clr count", cnt_a, 0);
    check_eq("clr max", max_a, 0);
`endif
    idx = 9'd7; en = 3'b111; start = 1;
    tick();
    start = 0;
    tick();
    idx = 9'd8; en = 3'b000; start = 1; clr = 1;
    tick();
    start = 0; clr = 0;
    check_eq("set beats clr", ovr_a, 1);
`ifdef RENDER_SCHED_STATS_EN
    check_eq("count after set+clr", cnt_a, 1);
`endif
    check_eq("no-drain restart line", line_a, 8);
    check_eq("no-drain restart busy", busy_a, 1);
    tick();
    tick();
    check_eq("line8 idle", busy_a, 0);
`ifdef RENDER_SCHED_STATS_EN
    check_eq("max render cycles", max_a, 2);
`endif

    // Reset mid-RENDER with a fetch outstanding
    idx = 9'd9; en = 3'b111; start = 1;
    tick();
    start = 0;
    tick();
    req_a = 3'b001;
    tick();
    check_eq("pre-reset vreq", vreq_a, 1);
    rst = 1;
    tick();
    rst = 0; req_a = 3'b011;
    check_eq("reset vreq", vreq_a, 0);
    check_eq("reset grant", gnt_a, 3);
    check_eq("reset busy", busy_a, 0);
    check_eq("reset overrun", ovr_a, 0);
    tick();
    check_eq("reset rr pointer", gnt_a, 0);
    req_a = '0; vack_a = 1;
    tick();
    vack_a = 0;
    check_eq("final grant idle", gnt_a, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
